// File: rtl/lab8_soc_sysid_checker.sv
// Avalon-MM read master that fetches sysid words 0 (ID) and 1 (timestamp) and flags any mismatch.
// Optional periodic re-check after a passing result when SYSID_RECHECK_EN is defined.
module lab8_soc_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'h5802_6C5F,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          RECHECK_PERIOD = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_ID = 3'd1;
   localparam logic [2:0] S_RD_TS = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || RECHECK_PERIOD < 1) begin : g_bad_cfg
      $error("lab8_soc_sysid_checker: parameter out of range");
   end

   logic [2:0]  state;
   logic        start_q;
   logic [15:0] wait_cnt;
   logic        auto_start;
   logic        launch;

`ifdef SYSID_RECHECK_EN
   localparam logic [31:0] IDLE_LAST = 32'(RECHECK_PERIOD - 1);
   logic [31:0] idle_cnt;

   // Only a passing result re-arms; a failed re-check stays parked in DONE.
   assign auto_start = (state == S_DONE) && pass && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clock) begin
      if (reset)
         idle_cnt <= '0;
      else if (state == S_DONE && pass && !start_q && !auto_start)
         idle_cnt <= idle_cnt + 32'd1;
      else
         idle_cnt <= '0;
   end
`else
   assign auto_start = 1'b0;
`endif

   assign launch      = (state == S_IDLE || state == S_DONE) && (start_q || auto_start);
   assign avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
   assign avm_address = (state == S_RD_TS);
   assign busy        = (state == S_RD_ID) || (state == S_RD_TS) || (state == S_CHECK);
   assign done        = (state == S_DONE);

   // start is registered first; the FSM acts on it one edge later.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         start_q  <= 1'b0;
         wait_cnt <= '0;
         pass     <= 1'b0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         start_q <= start;
         case (state)
            S_IDLE, S_DONE: begin
               if (launch) begin
                  state    <= S_RD_ID;
                  wait_cnt <= '0;
                  pass     <= 1'b0;
                  id_ok    <= 1'b0;
                  ts_ok    <= 1'b0;
                  timeout  <= 1'b0;
               end
            end
            S_RD_ID, S_RD_TS: begin
               if (!avm_waitrequest) begin
                  wait_cnt <= '0;
                  if (state == S_RD_ID) begin
                     id_value <= avm_readdata;
                     state    <= S_RD_TS;
                  end else begin
                     ts_value <= avm_readdata;
                     state    <= S_CHECK;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= S_DONE;
                  timeout <= 1'b1;
                  pass    <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            S_CHECK: begin
               id_ok <= (id_value == EXPECTED_ID);
               ts_ok <= (ts_value == EXPECTED_TS);
               pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS) && !timeout;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lab8_soc_sysid_checker.sv
// Randomized bench for lab8_soc_sysid_checker: a stalling sysid slave model plus a
// transaction-level outcome model (latency, captures, flags) derived from stall counts.
module tb_lab8_soc_sysid_checker;

   localparam int          T       = 8;
   localparam int          PERIOD  = 16;
   localparam logic [31:0] EXP_ID  = 32'h0000_0000;
   localparam logic [31:0] EXP_TS  = 32'h5802_6C5F;

   logic        clock = 0, reset = 1, start = 0;
   logic        avm_address, avm_read, avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   lab8_soc_sysid_checker #(.TIMEOUT_CYCLES(T), .RECHECK_PERIOD(PERIOD)) dut (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .busy(busy), .done(done), .pass(pass),
      .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
      .id_value(id_value), .ts_value(ts_value));

   always #5 clock = ~clock;

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Slave model: each read stalls s_id / s_ts cycles, then returns the word.
   int          s_id = 0, s_ts = 0, stall_cnt = 0;
   logic [31:0] id_word = 0, ts_word = 0;
   assign avm_readdata    = avm_address ? ts_word : id_word;
   assign avm_waitrequest = avm_read && (stall_cnt < (avm_address ? s_ts : s_id));

   always @(posedge clock) begin
      if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
      else stall_cnt <= stall_cnt + 1;
   end

   // Monitor: completed reads, read cycles, and command stability under stall.
   int   comp_addr[$];
   int   comp_cyc[$];
   int   read_cyc = 0;
   bit   addr1_seen = 0;
   bit   prev_stall = 0;
   logic prev_addr = 0;
   always @(negedge clock) begin
      if (prev_stall && !timeout && !reset)
         chk("stall_hold", {avm_read, avm_address}, {1'b1, prev_addr});
      prev_stall = avm_read && avm_waitrequest && !reset;
      prev_addr  = avm_address;
      if (avm_read && !avm_waitrequest) begin
         comp_addr.push_back(int'(avm_address));
         comp_cyc.push_back(cyc);
      end
      if (avm_read) read_cyc++;
      if (avm_read && avm_address) addr1_seen = 1;
   end

   logic [31:0] m_id = 0, m_ts = 0;
   int          last_done_cyc = 0;

   task automatic run_check(input int sid, input int sts, input logic [31:0] idw,
                            input logic [31:0] tsw, input bit dbl, input string tag);
      int c, k, rel, n_exp;
      bit e_to, e_idok, e_tsok;
      s_id = sid; s_ts = sts; id_word = idw; ts_word = tsw;
      comp_addr.delete(); comp_cyc.delete(); addr1_seen = 0;
      @(negedge clock); c = cyc; start = 1;
      @(negedge clock); start = 0;
      @(negedge clock);
      chk({tag, ":busy"}, {busy, done}, 2'b10);
      if (dbl) start = 1;
      @(negedge clock); start = 0;
      k = 0;
      while (!done && k < 100) begin @(negedge clock); k++; end
      if (!done) chk({tag, ":done_wait"}, 0, 1);
      last_done_cyc = cyc;
      // Outcome model from stall counts against the timeout budget.
      e_idok = 0; e_tsok = 0;
      if (sid >= T) begin
         e_to = 1; rel = 1 + T; n_exp = 0;
      end else if (sts >= T) begin
         e_to = 1; rel = 2 + sid + T; n_exp = 1; m_id = idw;
      end else begin
         e_to = 0; rel = 4 + sid + sts; n_exp = 2; m_id = idw; m_ts = tsw;
         e_idok = (idw == EXP_ID); e_tsok = (tsw == EXP_TS);
      end
      chk({tag, ":done_edge"}, cyc - c - 1, rel);
      chk({tag, ":flags"}, {busy, avm_read, timeout, id_ok, ts_ok, pass},
          {1'b0, 1'b0, e_to, e_idok, e_tsok, e_idok & e_tsok & !e_to});
      chk({tag, ":values"}, {id_value, ts_value}, {m_id, m_ts});
      chk({tag, ":n_reads"}, comp_addr.size(), n_exp);
      if (comp_addr.size() == n_exp) begin
         if (n_exp >= 1) chk({tag, ":rd0"}, {comp_addr[0], comp_cyc[0] - c}, {32'd0, 32'(2 + sid)});
         if (n_exp == 2) chk({tag, ":rd1"}, {comp_addr[1], comp_cyc[1] - c}, {32'd1, 32'(3 + sid + sts)});
      end
      if (sid >= T) chk({tag, ":no_addr1"}, addr1_seen, 0);
   endtask

   initial begin
      int k, rc0;
      repeat (3) @(negedge clock);
      chk("reset_state", {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout, id_value, ts_value}, '0);
      reset = 0;
      @(negedge clock);
      chk("idle_state", {avm_read, busy, done}, 3'b000);

      run_check(0, 0, 32'h0, EXP_TS, 0, "t1_pass");
      run_check(0, 0, 32'h0, 32'h5802_6C60, 0, "t2_badts");
      run_check(20, 0, 32'h0, EXP_TS, 0, "t3_to_id");
      run_check(3, 3, 32'h0, EXP_TS, 0, "t4_stall");
      run_check(1, 20, 32'h0, EXP_TS, 0, "to_ts");
      run_check(0, 0, 32'h0, EXP_TS, 1, "dbl_start");
      run_check(T - 1, T - 1, 32'h0, EXP_TS, 0, "max_stall");
      run_check(0, 0, 32'hDEAD_0001, EXP_TS, 0, "bad_id");

      for (int i = 0; i < 20; i++)
         run_check($urandom_range(0, 9), $urandom_range(0, 9),
                   ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom,
                   ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom,
                   ($urandom_range(0, 3) == 0), "rand");

      // Reset while the timestamp read is stalled.
      s_id = 0; s_ts = 50; id_word = 32'h1234_5678; ts_word = EXP_TS;
      @(negedge clock); start = 1;
      @(negedge clock); start = 0;
      k = 0;
      while (!(avm_read && avm_address) && k < 20) begin @(negedge clock); k++; end
      chk("rst_reach_ts", {avm_read, avm_address}, 2'b11);
      @(negedge clock); #1 reset = 1;
      @(negedge clock);
      chk("rst_mid_read", {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout, id_value, ts_value}, '0);
      #1 reset = 0;
      m_id = 0; m_ts = 0;
      run_check(0, 0, 32'h0, EXP_TS, 0, "post_rst");

`ifdef SYSID_RECHECK_EN
      id_word = 32'h0000_0001;
      k = 0;
      while (!avm_read && k < 40) begin @(negedge clock); k++; end
      chk("recheck_gap", cyc - last_done_cyc, PERIOD);
      k = 0;
      while (!done && k < 40) begin @(negedge clock); k++; end
      chk("recheck_fail", {done, pass, id_ok, ts_ok, timeout}, 5'b10010);
      rc0 = read_cyc;
      repeat (3 * PERIOD) @(negedge clock);
      chk("recheck_sticky", {done, pass, 32'(read_cyc - rc0)}, {1'b1, 1'b0, 32'd0});
`else
      rc0 = read_cyc;
      repeat (3 * PERIOD) @(negedge clock);
      chk("no_auto_start", {done, pass, 32'(read_cyc - rc0)}, {1'b1, 1'b1, 32'd0});
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
